// File: rtl/rr_sel_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin select arbiter.
// The master side drives requests. The slave side (the arbiter) drives the grant outputs.
interface rr_sel_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic               gnt_valid_o;

  modport master (output req_i, input gnt_o, gnt_idx_o, gnt_valid_o);
  modport slave  (input req_i, output gnt_o, gnt_idx_o, gnt_valid_o);
endinterface

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing the registered one-hot mux select.
// A grant is held for a bounded number of cycles while other requesters wait.
module rr_sel_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  rr_sel_arbiter_if.slave   bus
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0]  PTR_RST  = IDX_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic               others;
  logic               keep;
  logic               found;
  logic [IDX_W-1:0]   sel;
  int                 cand;

  // Circular search from ptr+1; the wrap is an explicit subtract, so any NUM_REQ works.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && bus.req_i[IDX_W'(cand)]) begin
        found = 1'b1;
        sel   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    others = |(bus.req_i & ~gnt_q);
    keep   = valid_q && bus.req_i[idx_q] && ((hold_q < HOLD_MAX) || !others);

    if (keep) begin
      if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
    end else if (found) begin
      gnt_d      = '0;
      gnt_d[sel] = 1'b1;
      idx_d      = sel;
      valid_d    = 1'b1;
      ptr_d      = sel;
      hold_d     = '0;
    end else begin
      gnt_d   = '0;
      valid_d = 1'b0;
      hold_d  = '0;
    end
  end

  // Pointer resets to the last index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= PTR_RST;
      hold_q  <= '0;
    end else begin
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.gnt_valid_o = valid_q;
endmodule

// File: doc/rr_sel_arbiter.md
# rr_sel_arbiter

Round-robin arbiter that generates the registered one-hot select driving the 4:1 bit mux stage. It samples NUM_REQ request lines and grants exactly one requester per cycle, or none. A granted requester keeps the grant while it holds its request, for at most MAX_HOLD consecutive cycles when other requesters are waiting. gnt_o connects directly to the mux sel_i input. gnt_idx_o is the binary index of the same grant, for debug and for encoded consumers.

## Interface
- NUM_REQ, 4: number of requesters. Equals the mux select width.
- MAX_HOLD, 4: maximum consecutive grant cycles per requester under contention. Must be ≥1.
- IDX_W, $clog2(NUM_REQ): width of gnt_idx_o. This is a derived localparam.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset. One clock domain only.
- req_i  input  NUM_REQ  request vector. Bit n set means requester n wants the mux.
- gnt_o  output  NUM_REQ  registered one-hot grant, or all-zero when idle. Feeds mux sel_i.
- gnt_idx_o  output  IDX_W  binary index of the granted bit. Holds its last value when idle.
- gnt_valid_o  output  1  registered; equals |gnt_o.

## Operation
Internal state:
- ptr: index of the last granted requester.
- hold_cnt: counts 0..MAX_HOLD-1 and saturates at MAX_HOLD-1.
- cur: the registered grant index.

Reset values:
- gnt_o=0, gnt_idx_o=0, gnt_valid_o=0.
- ptr=NUM_REQ-1, so requester 0 has first priority after reset.
- hold_cnt=0.

Each rising edge evaluates the rules in order. g is the current grant index, valid only when gnt_valid_o=1. others is 1 if any req_i bit other than g is set.
- KEEP: gnt_valid_o=1, req_i[g]=1, and (hold_cnt<MAX_HOLD-1 or others=0).
  - Grant is unchanged.
  - hold_cnt increments, saturating at MAX_HOLD-1.
  - ptr is unchanged.
- ROTATE: KEEP fails and req_i≠0.
  - Search req_i circularly, starting at (ptr+1) mod NUM_REQ.
  - The first set bit n becomes the grant: gnt_o=1<<n, gnt_idx_o=n, ptr=n, hold_cnt=0.
  - If the hold expired and req_i[g] is the only other candidate found, g wins again with hold_cnt=0. This only happens when others=0, which KEEP already covers.
- IDLE: req_i=0.
  - gnt_o=0, gnt_valid_o=0, hold_cnt=0.
  - ptr and gnt_idx_o are unchanged.

Invariants:
- gnt_o is never multi-hot.
- A grant is only ever issued to a bit that was set in req_i at the sampling edge.

Wrap-around: the search index NUM_REQ-1 is followed by 0. The modulo is implemented explicitly, so it must not depend on NUM_REQ being a power of two.

Fairness: with all requests asserted continuously, each requester gets exactly MAX_HOLD consecutive cycles, in order 0,1,…,NUM_REQ-1,0,…

MAX_HOLD=1: under contention the grant rotates every cycle. A lone requester keeps the grant indefinitely.

## Timing
- Request-to-grant latency is 1 cycle: req_i is sampled at edge k, and gnt_o is valid after edge k.
- Request-drop-to-release latency is 1 cycle. The grant moves or clears at the next edge, never later.
- All outputs come from flops. There is no combinational path from req_i to any output.
- reset asserted at any time, including mid-hold:
  - All outputs clear immediately, without waiting for clk.
  - The first edge after deassertion follows the post-reset priority, requester 0 first.
- Requests that change between edges are ignored. Only values present at the edge matter.

## Test plan
- Reset: assert reset for 3 cycles with req_i=1111 → gnt_o=0000, gnt_valid_o=0, gnt_idx_o=0 throughout. After release, the first edge gives gnt_o=0001.
- Full contention, MAX_HOLD=4: req_i=1111 held for 20 cycles → gnt_o=0001×4, 0010×4, 0100×4, 1000×4, 0001×4. gnt_idx_o tracks the grant, gnt_valid_o=1 throughout.
- Lone requester: req_i=0100 held for 10 cycles → gnt_o=0100 for all 10 cycles, with no forced release. hold_cnt saturates at 3.
- Drop and hand-off: req_i=0001 for 2 cycles, then 1000 → gnt_o=0001, 0001, then 1000 one cycle after the change.
- Idle pointer retention:
  - Stimulus: grant 0010, then req_i=0000 for 3 cycles, then req_i=1111.
  - Required response: gnt_o=0000 and gnt_valid_o=0 during idle, with gnt_idx_o held at 1. After the idle, the first grant is 0100.
- Async reset mid-hold: with gnt_o=0100 and hold_cnt=2, pulse reset between edges → gnt_o=0000 before the next edge. After release with req_i=1111, gnt_o=0001.
